// File: rtl/bbc_pkg.sv
// Shared state type and source/destination set encoding for banked_buf_ctrl.
package bbc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StDrain,
        StDone
    } state_e;

    localparam logic [1:0] SRC_IMG  = 2'd0;
    localparam logic [1:0] SRC_RES0 = 2'd1;
    localparam logic [1:0] SRC_RES1 = 2'd2;

    // The destination is always the result set that is not the current source.
    function automatic logic [1:0] next_dst(input logic [1:0] src);
        return (src == SRC_RES0) ? SRC_RES1 : SRC_RES0;
    endfunction

endpackage

// File: rtl/bank_ram.sv
// Single-port inferred bank RAM with a configurable read latency of RAM_LAT cycles.
module bank_ram #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned AW      = 14,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q  [2**AW];
    logic [DATA_W-1:0] pipe_q [RAM_LAT];

    // Later stages shift every cycle so back-to-back reads stay pipelined.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            pipe_q[0] <= mem_q[addr_i];
        end
        for (int i = 1; i < RAM_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rdata_o = pipe_q[RAM_LAT-1];

endmodule

// File: rtl/banked_buf_ctrl.sv
// Image/result bank controller: loads the image set, ping-pongs two result sets per layer,
// then serves readout from the final result set.
module banked_buf_ctrl
    import bbc_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned AW        = 14,
    parameter int unsigned RAM_LAT   = 1,
    parameter int unsigned LCNT_W    = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_load_i,
    input  logic                        ld_valid_i,
    output logic                        ld_ready_o,
    input  logic                        ld_last_i,
    input  logic [AW-1:0]               ld_addr_i,
    input  logic [NUM_BANKS*DATA_W-1:0] ld_data_i,
    input  logic                        rd_valid_i,
    output logic                        rd_ready_o,
    input  logic [AW-1:0]               rd_addr_i,
    output logic [NUM_BANKS*DATA_W-1:0] rd_data_o,
    output logic                        rd_data_valid_o,
    input  logic                        res_valid_i,
    output logic                        res_ready_o,
    input  logic [AW-1:0]               res_addr_i,
    input  logic [NUM_BANKS*DATA_W-1:0] res_data_i,
    input  logic                        layer_done_i,
    input  logic                        finish_i,
    output logic [1:0]                  src_sel_o,
    output logic [LCNT_W-1:0]           layer_cnt_o,
    output logic                        busy_o
);

    localparam int unsigned WORD_W = NUM_BANKS * DATA_W;

    state_e            state_q;
    logic              ld_ready_q, rd_ready_q, res_ready_q, busy_q;
    logic              fin_q;
    logic [1:0]        drain_cnt_q;
    logic [1:0]        src_sel_q;
    logic [LCNT_W-1:0] layer_cnt_q;

    logic [RAM_LAT-1:0] vld_q;
    logic [1:0]         src_pipe_q [RAM_LAT];

    logic       ld_acc, rd_acc, res_acc;
    logic [1:0] dst_sel;

    logic [2:0]             set_we, set_re;
    logic [2:0][AW-1:0]     set_addr;
    logic [2:0][WORD_W-1:0] set_wdata;
    logic [2:0][WORD_W-1:0] set_rdata;

    assign ld_acc  = ld_valid_i  & ld_ready_q;
    assign rd_acc  = rd_valid_i  & rd_ready_q;
    assign res_acc = res_valid_i & res_ready_q;
    assign dst_sel = next_dst(src_sel_q);

    always_comb begin
        set_we[0] = ld_acc;
        set_we[1] = res_acc && (dst_sel == SRC_RES0);
        set_we[2] = res_acc && (dst_sel == SRC_RES1);

        set_re[0] = rd_acc && (src_sel_q == SRC_IMG);
        set_re[1] = rd_acc && (src_sel_q == SRC_RES0);
        set_re[2] = rd_acc && (src_sel_q == SRC_RES1);

        // Source and destination never coincide, so the port goes to whichever is writing.
        set_addr[0] = set_we[0] ? ld_addr_i  : rd_addr_i;
        set_addr[1] = set_we[1] ? res_addr_i : rd_addr_i;
        set_addr[2] = set_we[2] ? res_addr_i : rd_addr_i;

        set_wdata[0] = ld_data_i;
        set_wdata[1] = res_data_i;
        set_wdata[2] = res_data_i;
    end

    for (genvar s = 0; s < 3; s++) begin : g_set
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            bank_ram #(
                .DATA_W  (DATA_W),
                .AW      (AW),
                .RAM_LAT (RAM_LAT)
            ) u_bank (
                .clk_i   (clk_i),
                .we_i    (set_we[s]),
                .re_i    (set_re[s]),
                .addr_i  (set_addr[s]),
                .wdata_i (set_wdata[s][b*DATA_W +: DATA_W]),
                .rdata_o (set_rdata[s][b*DATA_W +: DATA_W])
            );
        end
    end

    // The set a read was issued against travels with its valid bit, so the mux is
    // immune to the source swap that happens at the end of DRAIN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                src_pipe_q[i] <= SRC_IMG;
            end
        end else begin
            vld_q[0]      <= rd_acc;
            src_pipe_q[0] <= src_sel_q;
            for (int i = 1; i < RAM_LAT; i++) begin
                vld_q[i]      <= vld_q[i-1];
                src_pipe_q[i] <= src_pipe_q[i-1];
            end
        end
    end

    always_comb begin
        rd_data_o = set_rdata[0];
        unique case (src_pipe_q[RAM_LAT-1])
            SRC_RES0: rd_data_o = set_rdata[1];
            SRC_RES1: rd_data_o = set_rdata[2];
            default:  rd_data_o = set_rdata[0];
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ld_ready_q  <= 1'b0;
            rd_ready_q  <= 1'b0;
            res_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
            drain_cnt_q <= 2'd0;
            src_sel_q   <= SRC_IMG;
            layer_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_load_i) begin
                        state_q     <= StLoad;
                        src_sel_q   <= SRC_IMG;
                        layer_cnt_q <= '0;
                        ld_ready_q  <= 1'b1;
                        rd_ready_q  <= 1'b0;
                        res_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                StLoad: begin
                    if (ld_acc && ld_last_i) begin
                        state_q     <= StCompute;
                        ld_ready_q  <= 1'b0;
                        rd_ready_q  <= 1'b1;
                        res_ready_q <= 1'b1;
                    end
                end
                StCompute: begin
                    if (finish_i || layer_done_i) begin
                        state_q     <= StDrain;
                        fin_q       <= finish_i;
                        drain_cnt_q <= 2'(RAM_LAT - 1);
                        rd_ready_q  <= 1'b0;
                        res_ready_q <= 1'b0;
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == 2'd0) begin
                        src_sel_q <= dst_sel;
                        if (layer_cnt_q != '1) begin
                            layer_cnt_q <= layer_cnt_q + 1'b1;
                        end
                        rd_ready_q <= 1'b1;
                        if (fin_q) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= StCompute;
                            res_ready_q <= 1'b1;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 2'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ld_ready_o      = ld_ready_q;
    assign rd_ready_o      = rd_ready_q;
    assign res_ready_o     = res_ready_q;
    assign busy_o          = busy_q;
    assign src_sel_o       = src_sel_q;
    assign layer_cnt_o     = layer_cnt_q;
    assign rd_data_valid_o = vld_q[RAM_LAT-1];

endmodule

// File: tb/tb_banked_buf_ctrl.sv
// Randomized bench for banked_buf_ctrl against a behavioural set/queue model;
// drives a default instance and a NUM_BANKS=2/DATA_W=16/RAM_LAT=3 instance.
module tb_banked_buf_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_COMP  = 2;
    localparam int M_DRAIN = 3;
    localparam int M_DONE  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_load, ld_valid, ld_last, rd_valid, res_valid, layer_done, finish;
    logic [13:0] ld_addr, rd_addr, res_addr;
    logic [31:0] ld_data, res_data;

    logic        a_ld_ready, a_rd_ready, a_res_ready, a_rd_data_valid, a_busy;
    logic [31:0] a_rd_data;
    logic [1:0]  a_src_sel;
    logic [3:0]  a_layer_cnt;
    logic        b_ld_ready, b_rd_ready, b_res_ready, b_rd_data_valid, b_busy;
    logic [31:0] b_rd_data;
    logic [1:0]  b_src_sel;
    logic [3:0]  b_layer_cnt;

    bit          use_b;
    logic        o_ld_ready, o_rd_ready, o_res_ready, o_rd_data_valid, o_busy;
    logic [31:0] o_rd_data;
    logic [1:0]  o_src_sel;
    logic [3:0]  o_layer_cnt;

    always #5 clk = ~clk;

    banked_buf_ctrl u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_load_i(start_load),
        .ld_valid_i(ld_valid), .ld_ready_o(a_ld_ready), .ld_last_i(ld_last),
        .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .rd_valid_i(rd_valid), .rd_ready_o(a_rd_ready), .rd_addr_i(rd_addr),
        .rd_data_o(a_rd_data), .rd_data_valid_o(a_rd_data_valid),
        .res_valid_i(res_valid), .res_ready_o(a_res_ready), .res_addr_i(res_addr),
        .res_data_i(res_data), .layer_done_i(layer_done), .finish_i(finish),
        .src_sel_o(a_src_sel), .layer_cnt_o(a_layer_cnt), .busy_o(a_busy)
    );

    banked_buf_ctrl #(
        .NUM_BANKS(2), .DATA_W(16), .AW(14), .RAM_LAT(3), .LCNT_W(4)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_load_i(start_load),
        .ld_valid_i(ld_valid), .ld_ready_o(b_ld_ready), .ld_last_i(ld_last),
        .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .rd_valid_i(rd_valid), .rd_ready_o(b_rd_ready), .rd_addr_i(rd_addr),
        .rd_data_o(b_rd_data), .rd_data_valid_o(b_rd_data_valid),
        .res_valid_i(res_valid), .res_ready_o(b_res_ready), .res_addr_i(res_addr),
        .res_data_i(res_data), .layer_done_i(layer_done), .finish_i(finish),
        .src_sel_o(b_src_sel), .layer_cnt_o(b_layer_cnt), .busy_o(b_busy)
    );

    assign o_ld_ready      = use_b ? b_ld_ready      : a_ld_ready;
    assign o_rd_ready      = use_b ? b_rd_ready      : a_rd_ready;
    assign o_res_ready     = use_b ? b_res_ready     : a_res_ready;
    assign o_rd_data_valid = use_b ? b_rd_data_valid : a_rd_data_valid;
    assign o_busy          = use_b ? b_busy          : a_busy;
    assign o_rd_data       = use_b ? b_rd_data       : a_rd_data;
    assign o_src_sel       = use_b ? b_src_sel       : a_src_sel;
    assign o_layer_cnt     = use_b ? b_layer_cnt     : a_layer_cnt;

    // Reference model: three word-wide sets, a mode, and a queue of due read results.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rexp_t;

    logic [31:0] m_mem [3][16];
    bit          m_wr  [3][16];
    rexp_t       rq [$];
    int          m_mode, m_src, m_cnt, m_drain, lat, cyc;
    bit          m_fin;
    int          n_checks, n_pass;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic idle_inputs();
        start_load = 0; ld_valid = 0; ld_last = 0; rd_valid = 0; res_valid = 0;
        layer_done = 0; finish = 0;
        ld_addr = '0; rd_addr = '0; res_addr = '0; ld_data = '0; res_data = '0;
    endtask

    task automatic model_step();
        bit ld_acc, rd_acc, res_acc;
        int dst;
        rexp_t e;
        cyc++;
        ld_acc  = (m_mode == M_LOAD) && ld_valid;
        rd_acc  = (m_mode == M_COMP || m_mode == M_DONE) && rd_valid;
        res_acc = (m_mode == M_COMP) && res_valid;
        dst     = (m_src == 1) ? 2 : 1;
        if (rd_acc) begin
            e.due  = cyc + lat - 1;
            e.data = m_mem[m_src][int'(rd_addr)];
            rq.push_back(e);
        end
        if (ld_acc) begin
            m_mem[0][int'(ld_addr)] = ld_data;
            m_wr[0][int'(ld_addr)]  = 1;
        end
        if (res_acc) begin
            m_mem[dst][int'(res_addr)] = res_data;
            m_wr[dst][int'(res_addr)]  = 1;
        end
        case (m_mode)
            M_IDLE, M_DONE: if (start_load) begin m_mode = M_LOAD; m_src = 0; m_cnt = 0; end
            M_LOAD: if (ld_acc && ld_last) m_mode = M_COMP;
            M_COMP: if (finish || layer_done) begin
                m_mode = M_DRAIN; m_fin = finish; m_drain = lat;
            end
            M_DRAIN: begin
                m_drain--;
                if (m_drain == 0) begin
                    m_src = dst;
                    if (m_cnt < 15) m_cnt++;
                    m_mode = m_fin ? M_DONE : M_COMP;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        bit exp_v;
        exp_v = (rq.size() > 0) && (rq[0].due == cyc);
        check_eq("ld_ready",  64'(o_ld_ready),  64'(m_mode == M_LOAD));
        check_eq("rd_ready",  64'(o_rd_ready),  64'(m_mode == M_COMP || m_mode == M_DONE));
        check_eq("res_ready", 64'(o_res_ready), 64'(m_mode == M_COMP));
        check_eq("busy",      64'(o_busy),      64'(m_mode >= M_LOAD && m_mode <= M_DRAIN));
        check_eq("src_sel",   64'(o_src_sel),   64'(m_src));
        check_eq("layer_cnt", 64'(o_layer_cnt), 64'(m_cnt));
        check_eq("rd_data_valid", 64'(o_rd_data_valid), 64'(exp_v));
        if (exp_v) begin
            check_eq("rd_data", 64'(o_rd_data), 64'(rq[0].data));
            void'(rq.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_src = 0; m_cnt = 0; m_fin = 0; m_drain = 0;
        rq.delete();
    endtask

    // Called on a settled timestep; asserts reset, checks reset values, releases on a negedge.
    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1;
    endtask

    task automatic drain_out();
        for (int g = 0; g < 8 && m_mode == M_DRAIN; g++) tick();
    endtask

    task automatic rand_ops();
        int a;
        rd_valid = 0; res_valid = 0;
        a = $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1 && m_wr[m_src][a]) begin
            rd_valid = 1; rd_addr = 14'(a);
        end
        if ($urandom_range(0, 2) == 0) begin
            res_valid = 1; res_addr = 14'($urandom_range(0, 15)); res_data = $urandom;
        end
    endtask

    task automatic load_beat(input int addr, input logic [31:0] data, input bit last);
        ld_valid = 1; ld_addr = 14'(addr); ld_data = data; ld_last = last;
        tick();
        ld_valid = 0; ld_last = 0;
    endtask

    logic [31:0] img_words [3];

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        img_words[0] = 32'h04030201;
        img_words[1] = 32'h08070605;
        img_words[2] = 32'h0C0B0A09;
        n_checks = 0; n_pass = 0; cyc = 0; use_b = 0; lat = 1;
        foreach (m_wr[s, a]) m_wr[s][a] = 0;
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        do_reset();

        // Image load with an ignored ld_last-without-valid, then back-to-back readback.
        start_load = 1; tick(); start_load = 0;
        ld_last = 1; tick(); ld_last = 0;
        for (int i = 0; i < 3; i++) load_beat(i, img_words[i], i == 2);
        check_eq("ld_ready_drop", 64'(o_ld_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1; rd_addr = 14'(i); tick();
            check_eq("img_rd", 64'(o_rd_data), 64'(img_words[i]));
        end
        rd_valid = 0; tick(); tick();

        // First swap: result written to RES0 is readable once RES0 becomes the source.
        res_valid = 1; res_addr = 14'd5; res_data = 32'hDEADBEEF; tick(); res_valid = 0;
        layer_done = 1; tick(); layer_done = 0;
        check_eq("drain_rd_ready", 64'(o_rd_ready), 64'(0));
        drain_out();
        check_eq("src_l1", 64'(o_src_sel), 64'(1));
        check_eq("cnt_l1", 64'(o_layer_cnt), 64'(1));
        rd_valid = 1; rd_addr = 14'd5; tick(); rd_valid = 0;
        check_eq("res0_rd", 64'(o_rd_data), 64'h00000000DEADBEEF);

        // Read accepted with layer_done must return pre-swap (RES0) data during DRAIN.
        res_valid = 1; res_addr = 14'd5; res_data = 32'h11223344; tick(); res_valid = 0;
        rd_valid = 1; rd_addr = 14'd5; layer_done = 1; tick();
        rd_valid = 0; layer_done = 0;
        check_eq("preswap_rd", 64'(o_rd_data), 64'h00000000DEADBEEF);
        drain_out();
        check_eq("src_l2", 64'(o_src_sel), 64'(2));

        // Random compute traffic with occasional swaps and ignored start_load pulses.
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            layer_done = (m_mode == M_COMP) && ($urandom_range(0, 24) == 0);
            start_load = ($urandom_range(0, 39) == 0);
            tick();
        end
        idle_inputs(); tick(); drain_out();

        // finish alone, then DONE readout with writes refused.
        finish = 1; tick(); finish = 0; drain_out();
        for (int i = 0; i < 6; i++) begin
            rand_ops(); res_valid = 1; tick();
        end
        idle_inputs(); tick();

        // Restart; layer_done and finish together go to DONE with src RES0.
        start_load = 1; tick(); start_load = 0;
        for (int i = 8; i < 11; i++) load_beat(i, $urandom, i == 10);
        layer_done = 1; finish = 1; tick(); layer_done = 0; finish = 0;
        drain_out();
        check_eq("done_src", 64'(o_src_sel), 64'(1));
        check_eq("done_rd_ready", 64'(o_rd_ready), 64'(1));
        check_eq("done_busy", 64'(o_busy), 64'(0));
        res_valid = 1; res_addr = 14'd3; res_data = 32'h0BAD0BAD;
        repeat (5) tick();
        check_eq("done_res_ready", 64'(o_res_ready), 64'(0));
        idle_inputs(); tick();

        // Reset while a read is in flight during DRAIN; image RAM must survive.
        start_load = 1; tick(); start_load = 0;
        load_beat(11, 32'hCAFEF00D, 1);
        rd_valid = 1; rd_addr = 14'd0; layer_done = 1;
        @(posedge clk);
        #1;
        do_reset();
        check_eq("rst_rd_valid", 64'(o_rd_data_valid), 64'(0));
        tick(); tick();
        start_load = 1; tick(); start_load = 0;
        load_beat(12, 32'h55AA55AA, 1);
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1; rd_addr = 14'(i); tick();
            check_eq("retained_rd", 64'(o_rd_data), 64'(img_words[i]));
        end
        idle_inputs(); tick();

        // Second instance: wider banks, RAM_LAT=3, 17 swaps saturating the layer counter.
        use_b = 1; lat = 3;
        foreach (m_wr[s, a]) m_wr[s][a] = 0;
        do_reset();
        start_load = 1; tick(); start_load = 0;
        for (int i = 0; i < 16; i++) load_beat(i, $urandom, i == 15);
        rd_valid = 1; rd_addr = 14'd4; tick(); rd_valid = 0;
        check_eq("lat3_c1", 64'(o_rd_data_valid), 64'(0));
        tick();
        check_eq("lat3_c2", 64'(o_rd_data_valid), 64'(0));
        tick();
        check_eq("lat3_c3", 64'(o_rd_data_valid), 64'(1));
        tick();
        for (int k = 0; k < 17; k++) begin
            repeat (3) begin rand_ops(); tick(); end
            rand_ops(); layer_done = 1; tick(); layer_done = 0;
            for (int g = 0; g < 8 && m_mode == M_DRAIN; g++) begin rand_ops(); tick(); end
            check_eq("alt_src", 64'(o_src_sel), 64'((k % 2 == 0) ? 1 : 2));
        end
        idle_inputs(); repeat (4) tick();
        check_eq("sat_cnt", 64'(o_layer_cnt), 64'(15));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/banked_buf_ctrl.md
Name: banked_buf_ctrl

Overview:
Parametrised successor to the fixed four-bank image/result memory block of the CNN accelerator. It owns NUM_BANKS parallel image banks and two ping-pong result bank sets, and sequences them through one FSM: image load, per-layer compute with source/destination swapping, and final readout. It sits between the Avalon image loader and the conv/dense datapath.

Parameters:
NUM_BANKS, 4, parallel banks per set; one word lane per bank
DATA_W, 8, bits per bank word
AW, 14, bank address width; depth = 2**AW, all sets
RAM_LAT, 1, read latency of bank RAM in cycles (1..3)
LCNT_W, 4, layer counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_load  in  1  pulse: begin image load, clear layer state
ld_valid  in  1  loader word valid
ld_ready  out  1  loader word accepted when ld_valid&ld_ready
ld_last  in  1  qualifies final load word
ld_addr  in  AW  load address, same for all banks
ld_data  in  NUM_BANKS*DATA_W  lane i -> image bank i
rd_valid  in  1  datapath read request
rd_ready  out  1  read accepted
rd_addr  in  AW  read address
rd_data  out  NUM_BANKS*DATA_W  read word from current source set
rd_data_valid  out  1  rd_data valid, RAM_LAT cycles after accept
res_valid  in  1  result write request
res_ready  out  1  result write accepted
res_addr  in  AW  result address
res_data  in  NUM_BANKS*DATA_W  result word to current destination set
layer_done  in  1  pulse: current layer complete, swap sets
finish  in  1  pulse: last layer complete, enter readout
src_sel  out  2  0=image, 1=RES0, 2=RES1
layer_cnt  out  LCNT_W  completed layers
busy  out  1  high in LOAD, COMPUTE, DRAIN

Behaviour:
- FSM states: IDLE, LOAD, COMPUTE, DRAIN, DONE. Reset to IDLE.
- Reset values: ld_ready=0, rd_ready=0, res_ready=0, rd_data_valid=0, src_sel=0, layer_cnt=0, busy=0. Reset clears the valid pipeline and any pending swap. RAM contents are retained. rd_data is don't-care while rd_data_valid=0.
- ld_ready=1 only in LOAD. rd_ready=1 only in COMPUTE and DONE. res_ready=1 only in COMPUTE. All three are registered and depend on state only, never on the requests.
- IDLE/DONE + start_load -> LOAD. Set src_sel=0 and layer_cnt=0. Destination set is RES0.
- LOAD: each accepted beat writes lane i to image bank i at ld_addr. An accepted beat with ld_last -> COMPUTE next cycle. ld_last without ld_valid is ignored.
- COMPUTE: an accepted read samples the src set at rd_addr. rd_data_valid pulses exactly RAM_LAT cycles later, one pulse per accept, fully pipelined at one read per cycle. An accepted result write goes to the destination set in the same cycle. The destination is always the RES set not equal to src (RES0 when src=image). Source and destination never coincide, so no read/write collision exists.
- COMPUTE + layer_done or finish -> DRAIN. A request accepted in the same cycle is honoured. finish has priority over layer_done; record which one fired.
- DRAIN: all readies are 0. Hold RAM_LAT cycles so in-flight reads complete on the old source. Then:
  - src_sel := old destination: 0->1, 1->2, 2->1.
  - layer_cnt saturates at 2**LCNT_W-1.
  - Go to COMPUTE if layer_done fired, DONE if finish fired.
- DONE: reads allowed from the final result set; writes refused. start_load restarts.
- layer_done, finish, and start_load outside their legal states are ignored. start_load in LOAD/COMPUTE/DRAIN is ignored.
- busy=1 in LOAD, COMPUTE, DRAIN.

Decomposition:
- Package bbc_pkg holds:
  - state enum typedef
  - src_sel encoding constants SRC_IMG=0, SRC_RES0=1, SRC_RES1=2
  - helper function next_dst(src)
- One sub-module bank_ram: single-port inferred RAM with parameters DATA_W, AW, RAM_LAT. It is instantiated in generate loops: NUM_BANKS x {image, RES0, RES1}.
- Read-data mux and the valid shift register stay in the top module.

Test Plan:
1. Reset mid-DRAIN with a read in flight -> next cycle all outputs are at reset values. No rd_data_valid pulse occurs. Bank data written before the reset reads back unchanged after a new start_load and ld_last.
2. start_load, then 3 beats at addr 0,1,2 with ld_data 0x04030201/0x08070605/0x0C0B0A09, last beat carrying ld_last -> ld_ready drops. Back-to-back reads at 0,1,2 return the same words with rd_data_valid exactly RAM_LAT cycles after each accept.
3. In COMPUTE, write res 0xDEADBEEF @5, then layer_done -> readies are 0 for RAM_LAT cycles. After that: src_sel=1, layer_cnt=1, read @5 returns 0xDEADBEEF. A second layer_done gives src_sel=2.
4. layer_done and finish asserted in the same cycle -> DONE with src_sel=1. rd_ready=1, res_ready=0, busy=0. A res_valid held high is never accepted.
5. Read accepted in the same cycle as layer_done -> its data comes from the pre-swap source and arrives during DRAIN. No extra rd_data_valid pulses.
6. Parameter sweep NUM_BANKS=2/DATA_W=16/RAM_LAT=3 and 17 layer_done pulses with LCNT_W=4 -> rd_data_valid latency is 3. layer_cnt saturates at 15. src_sel alternates 1/2.
